// File: rtl/pulse_tracer_pkg.sv
// Shared edge-select encodings and the popcount helper for the multi-channel pulse tracer.
package pulse_tracer_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Channels are zero-extended to 32 bits, so a 6-bit result always suffices.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int k = 0; k < 32; k++) begin
      n = n + {5'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pulse_tracer_ch.sv
// One channel: two-flop synchroniser, symmetric run-length filter and registered edge pulses.
module pulse_tracer_ch #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_noisy,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_state;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          r_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_noisy;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any sample matching the accepted level restarts the run.
      if (r_sync2 == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_state <= r_sync2;
        r_cnt   <= '0;
        r_rise  <= r_sync2;
        r_fall  <= !r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable = r_state;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/pulse_tracer_mc.sv
// Multi-channel glitch filter: per-channel filters plus mode gating and a saturating event counter.
module pulse_tracer_mc
  import pulse_tracer_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int FILTER_LEN = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] i_noisy_in,
  input  logic [MODE_W-1:0]   i_edge_mode,
  input  logic                i_clear,
  output logic [CHANNELS-1:0] o_stable_out,
  output logic [CHANNELS-1:0] o_rise_pulse,
  output logic [CHANNELS-1:0] o_fall_pulse,
  output logic [CHANNELS-1:0] o_event_pulse,
  output logic                o_any_event,
  output logic [CNT_W-1:0]    o_event_count
);

  generate
    if (FILTER_LEN < 1) begin : g_bad_filter_len
      $error("pulse_tracer_mc: FILTER_LEN must be >= 1");
    end
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
      $error("pulse_tracer_mc: CHANNELS must be in 1..32");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pulse_tracer_mc: CNT_W must be >= 1");
    end
  endgenerate

  localparam int SUM_W = ((CNT_W > 6) ? CNT_W : 6) + 1;

  logic [CHANNELS-1:0] w_stable;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_event;
  logic                w_rise_en;
  logic                w_fall_en;
  logic [31:0]         w_event_ext;
  logic [5:0]          w_pop;
  logic [SUM_W-1:0]    w_sum;
  logic [SUM_W-1:0]    w_max;
  logic [CNT_W-1:0]    r_count;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      pulse_tracer_ch #(
        .FILTER_LEN(FILTER_LEN)
      ) u_ch (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_noisy  (i_noisy_in[gi]),
        .o_stable (w_stable[gi]),
        .o_rise   (w_rise[gi]),
        .o_fall   (w_fall[gi])
      );
    end
  endgenerate

  // Mode gating is combinational so a mode change applies to a pulse already in flight.
  assign w_rise_en   = (i_edge_mode == EDGE_RISE) || (i_edge_mode == EDGE_BOTH);
  assign w_fall_en   = (i_edge_mode == EDGE_FALL) || (i_edge_mode == EDGE_BOTH);
  assign w_event     = (w_rise & {CHANNELS{w_rise_en}}) | (w_fall & {CHANNELS{w_fall_en}});
  assign w_event_ext = 32'(w_event);
  assign w_pop       = popcount32(w_event_ext);
  assign w_sum       = SUM_W'(r_count) + SUM_W'(w_pop);
  assign w_max       = SUM_W'({CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_sum > w_max) begin
      r_count <= {CNT_W{1'b1}};
    end else begin
      r_count <= w_sum[CNT_W-1:0];
    end
  end

  assign o_stable_out  = w_stable;
  assign o_rise_pulse  = w_rise;
  assign o_fall_pulse  = w_fall;
  assign o_event_pulse = w_event;
  assign o_any_event   = |w_event;
  assign o_event_count = r_count;

endmodule
